// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional checksum stage is compiled in with `define IMEM_LOAD_CKSUM_EN.
package imem_pkg;

   localparam int IMEM_ADDR_W = 14;
   localparam int IMEM_LEN_W  = 16;
   localparam int WORD_BYTES  = 4;
   localparam int WORD_W      = 8 * WORD_BYTES;
   localparam int IDX_W       = $clog2(WORD_BYTES);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN0  = 3'd1,
      ST_LEN1  = 3'd2,
      ST_DATA  = 3'd3,
      ST_WRITE = 3'd4,
`ifdef IMEM_LOAD_CKSUM_EN
      ST_CKSUM = 3'd5,
`endif
      ST_DONE  = 3'd6
   } state_e;

   // States in which the loader is willing to take a stream byte.
   function automatic logic accepts_bytes(input state_e s);
      case (s)
         ST_LEN0, ST_LEN1, ST_DATA: accepts_bytes = 1'b1;
`ifdef IMEM_LOAD_CKSUM_EN
         ST_CKSUM:                  accepts_bytes = 1'b1;
`endif
         default:                   accepts_bytes = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits
// [8k+7:8k]. 'word' and 'full' reflect the byte being loaded this cycle,
// so the caller can register the completed word on the 4th byte's edge.
module byte_packer
   import imem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              load,
   input  logic [7:0]        byte_in,
   output logic [WORD_W-1:0] word,
   output logic              full
);

   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [WORD_W-1:0] word_q, word_d;

   // Next byte index and shift-in of the incoming byte from the top.
   always_comb begin
      // NOTE: every comb output gets a default first so no path infers a latch.
      idx_d  = idx_q;
      word_d = word_q;
      if (clear) begin
         idx_d = '0;
      end else if (load) begin
         idx_d  = idx_q + IDX_W'(1);
         word_d = {byte_in, word_q[WORD_W-1:8]};
      end
   end

   assign word = word_d;
   assign full = load & ~clear & (idx_q == IDX_W'(WORD_BYTES - 1));

   // Byte index register; a partial word is discarded on clear or reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment only.
      if (rst) idx_q <= '0;
      else     idx_q <= idx_d;
   end

   // Word shift register.
   always_ff @(posedge clk) begin
      // NOTE: pure datapath, no reset; each word is fully rewritten before use.
      word_q <= word_d;
   end

endmodule

// File: rtl/imem_load_ctrl.sv
// Boot-time instruction-ROM loader. Owns the ROM write port, shares the ROM
// address with the fetch stage, and fills ROM from a length-prefixed byte
// stream. Define IMEM_LOAD_CKSUM_EN to add a trailing 8-bit checksum byte.
module imem_load_ctrl
   import imem_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W,
   parameter int LEN_W  = IMEM_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_wen,
   output logic [31:0]       rom_din,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              load_err
);

`ifdef IMEM_LOAD_CKSUM_EN
   localparam state_e TAIL_ST = ST_CKSUM;
`else
   localparam state_e TAIL_ST = ST_DONE;
`endif

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [LEN_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]  len_full;
   logic              hold_stick_q, hold_stick_d;
   logic              cksum_bad;

`ifdef IMEM_LOAD_CKSUM_EN
   logic [7:0]        sum_q, sum_d;
`endif

   logic              byte_ready_q, byte_ready_d;
   logic              rom_wen_q, rom_wen_d;
   logic [31:0]       rom_din_q, rom_din_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              load_err_q, load_err_d;

   logic              is_idle, start_hit, abort_hit, take;
   logic              pk_clear, pk_load, pk_full;
   logic [WORD_W-1:0] pk_word;

   assign is_idle   = (state_q == ST_IDLE);
   assign start_hit = start & is_idle;
   assign abort_hit = abort & ~is_idle;
   // abort beats a same-cycle handshake: the byte is dropped
   assign take      = byte_valid & byte_ready_q & ~abort_hit;
   assign len_full  = LEN_W'({byte_data, cnt_q[7:0]});

   assign pk_clear  = start_hit | abort_hit;
   assign pk_load   = take & (state_q == ST_DATA);

   byte_packer u_packer (
      .clk     (clk),
      .rst     (rst),
      .clear   (pk_clear),
      .load    (pk_load),
      .byte_in (byte_data),
      .word    (pk_word),
      .full    (pk_full)
   );

   // Next-state, word pointer, remaining count and checksum.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      cksum_bad = 1'b0;
`ifdef IMEM_LOAD_CKSUM_EN
      sum_d     = sum_q;
`endif
      if (abort_hit) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_LEN0;
                  ptr_d   = '0;
                  cnt_d   = '0;
`ifdef IMEM_LOAD_CKSUM_EN
                  sum_d   = '0;
`endif
               end
            end
            ST_LEN0: begin
               if (take) begin
                  cnt_d   = LEN_W'(byte_data);
                  state_d = ST_LEN1;
               end
            end
            ST_LEN1: begin
               if (take) begin
                  cnt_d   = len_full;
                  state_d = (len_full == '0) ? TAIL_ST : ST_DATA;
               end
            end
            ST_DATA: begin
               if (take) begin
`ifdef IMEM_LOAD_CKSUM_EN
                  sum_d = sum_q + byte_data;
`endif
                  if (pk_full) state_d = ST_WRITE;
               end
            end
            ST_WRITE: begin
               ptr_d   = ptr_q + ADDR_W'(1);
               cnt_d   = cnt_q - LEN_W'(1);
               state_d = (cnt_q == LEN_W'(1)) ? TAIL_ST : ST_DATA;
            end
`ifdef IMEM_LOAD_CKSUM_EN
            ST_CKSUM: begin
               if (take) begin
                  if (byte_data == sum_q) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d   = ST_IDLE;
                     cksum_bad = 1'b1;
                  end
               end
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Registered outputs, derived from the state being entered.
   always_comb begin
      byte_ready_d = accepts_bytes(state_d);
      rom_wen_d    = (state_d == ST_WRITE);
      rom_din_d    = pk_full ? pk_word : rom_din_q;
      busy_d       = (state_d != ST_IDLE);
      done_d       = (state_d == ST_DONE);

      // A failed checksum keeps the core parked until a load succeeds.
      hold_stick_d = hold_stick_q;
      if (cksum_bad)                                    hold_stick_d = 1'b1;
      else if ((state_q == ST_DONE) && !abort_hit)      hold_stick_d = 1'b0;
      cpu_hold_d   = busy_d | hold_stick_d;

      load_err_d   = load_err_q;
      if (start_hit)                   load_err_d = 1'b0;
      else if (abort_hit || cksum_bad) load_err_d = 1'b1;
   end

   // State register, counters and output flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         cnt_q        <= '0;
         hold_stick_q <= 1'b0;
         byte_ready_q <= 1'b0;
         rom_wen_q    <= 1'b0;
         rom_din_q    <= '0;
         cpu_hold_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         load_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         hold_stick_q <= hold_stick_d;
         byte_ready_q <= byte_ready_d;
         rom_wen_q    <= rom_wen_d;
         rom_din_q    <= rom_din_d;
         cpu_hold_q   <= cpu_hold_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         load_err_q   <= load_err_d;
      end
   end

`ifdef IMEM_LOAD_CKSUM_EN
   // Running checksum over data bytes.
   always_ff @(posedge clk) begin
      if (rst) sum_q <= '0;
      else     sum_q <= sum_d;
   end
`endif

   // Fetch path sees only this mux: fetch address while idle, pointer otherwise.
   assign rom_addr   = is_idle ? fetch_addr : ptr_q;

   assign byte_ready = byte_ready_q;
   assign rom_wen    = rom_wen_q;
   assign rom_din    = rom_din_q;
   assign cpu_hold   = cpu_hold_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign load_err   = load_err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Scoreboard bench for imem_load_ctrl: expected ROM writes are queued when a
// load is issued and a monitor compares every rom_wen cycle against them.
module tb_imem_load_ctrl;

   localparam int ADDR_W = 14;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst, start, abort, byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic [ADDR_W-1:0] fetch_addr, rom_addr;
   logic              rom_wen, cpu_hold, busy, done, load_err;
   logic [31:0]       rom_din;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   int wr_cnt = 0;
   logic [ADDR_W-1:0] last_wr_addr;

   wr_t        exp_q[$];
   logic [7:0] stim_q[$];
   int         wr_cyc_q[$];

   imem_load_ctrl #(.ADDR_W(ADDR_W), .LEN_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .fetch_addr(fetch_addr), .rom_addr(rom_addr), .rom_wen(rom_wen),
      .rom_din(rom_din), .cpu_hold(cpu_hold), .busy(busy), .done(done),
      .load_err(load_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every ROM write must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         if (done) done_cnt++;
         if (rom_wen) begin
            wr_t e;
            wr_cnt++;
            last_wr_addr = rom_addr;
            wr_cyc_q.push_back(cyc);
            check("no_byte_ready_in_write", byte_ready, 0);
            check("write_expected", (exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("wr_addr", rom_addr, e.addr);
               check("wr_data", rom_din, e.data);
            end
         end
      end
   end

   // Offer one byte until accepted; byte_ready is registered, so its value at
   // the negedge is the one the DUT uses at the following posedge.
   task automatic send_byte(input logic [7:0] b, input bit rnd);
      bit hs = 0;
      for (int c = 0; c < 400 && !hs; c++) begin
         @(negedge clk);
         byte_data  = b;
         byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         hs = byte_valid & byte_ready;
         @(posedge clk);
      end
      check("byte_accepted", hs, 1);
   endtask

   task automatic fill_random(input int n_words);
      stim_q.delete();
      for (int i = 0; i < 4 * n_words; i++) stim_q.push_back(8'($urandom));
   endtask

   // One complete load from stim_q. abort_at >= 0 aborts after that many data
   // bytes; ck_flip corrupts the checksum byte when the checksum is built in.
   task automatic run_load(input int count, input bit rnd, input int abort_at,
                           input logic [7:0] ck_flip, input bit expect_done);
      int d0, w0, n_full, n_send;
      bit got;
      logic [7:0] sum;
      logic [15:0] cnt16;
      sum = 8'h00;
      cnt16 = 16'(count);
      n_full = (abort_at < 0) ? count : abort_at / 4;
      n_send = (abort_at < 0) ? 4 * count : abort_at;
      if (expect_done || abort_at >= 0) begin
         for (int i = 0; i < n_full; i++)
            exp_q.push_back('{addr: ADDR_W'(i % (1 << ADDR_W)),
                              data: {stim_q[4*i+3], stim_q[4*i+2], stim_q[4*i+1], stim_q[4*i]}});
      end else begin
         for (int i = 0; i < count; i++)
            exp_q.push_back('{addr: ADDR_W'(i % (1 << ADDR_W)),
                              data: {stim_q[4*i+3], stim_q[4*i+2], stim_q[4*i+1], stim_q[4*i]}});
      end
      d0 = done_cnt;
      w0 = wr_cnt;
      fetch_addr = ADDR_W'($urandom);

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_hold", cpu_hold, 1);
      check("start_ready", byte_ready, 1);
      check("start_clears_err", load_err, 0);

      send_byte(cnt16[7:0], rnd);
      send_byte(cnt16[15:8], rnd);
      for (int i = 0; i < n_send; i++) begin
         send_byte(stim_q[i], rnd);
         sum += stim_q[i];
      end

      if (abort_at >= 0) begin
         @(negedge clk);
         byte_valid = 1'b1;
         byte_data  = 8'hA5;
         abort      = 1'b1;
         @(negedge clk);
         abort      = 1'b0;
         byte_valid = 1'b0;
         check("abort_err", load_err, 1);
         check("abort_busy", busy, 0);
         check("abort_hold", cpu_hold, 0);
         check("abort_ready", byte_ready, 0);
         check("abort_rom_addr", rom_addr, fetch_addr);
         repeat (10) @(negedge clk);
         check("abort_write_count", wr_cnt - w0, n_full);
         check("abort_sb_empty", exp_q.size(), 0);
      end else begin
`ifdef IMEM_LOAD_CKSUM_EN
         send_byte(sum ^ ck_flip, rnd);
`endif
         got = 0;
         for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            byte_valid = 1'b0;
            if (done) got = 1;
         end
         if (expect_done) begin
            check("done_seen", got, 1);
            @(negedge clk);
            check("done_one_cycle", done, 0);
            check("hold_falls", cpu_hold, 0);
            check("busy_falls", busy, 0);
            check("idle_rom_addr", rom_addr, fetch_addr);
            @(negedge clk);
            check("done_pulses", done_cnt - d0, 1);
            check("write_count", wr_cnt - w0, count);
            check("sb_empty", exp_q.size(), 0);
         end else begin
            check("no_done", done_cnt - d0, 0);
            check("cksum_err", load_err, 1);
            check("cksum_hold", cpu_hold, 1);
            check("cksum_busy", busy, 0);
            check("cksum_writes", wr_cnt - w0, count);
            check("cksum_sb_empty", exp_q.size(), 0);
         end
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; abort = 1'b0;
      byte_valid = 1'b0; byte_data = 8'h00; fetch_addr = 14'h0123;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state and idle passthrough
      check("rst_ready", byte_ready, 0);
      check("rst_wen", rom_wen, 0);
      check("rst_din", rom_din, 0);
      check("rst_hold", cpu_hold, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", load_err, 0);
      check("idle_addr_0123", rom_addr, 14'h0123);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         fetch_addr = ADDR_W'($urandom);
         #1 check("idle_addr_rand", rom_addr, fetch_addr);
      end

      // Two words at full rate; writes exactly 5 cycles apart
      stim_q = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      wr_cyc_q.delete();
      run_load(2, 1'b0, -1, 8'h00, 1'b1);
      check("two_writes", wr_cyc_q.size(), 2);
      if (wr_cyc_q.size() == 2) check("write_gap", wr_cyc_q[1] - wr_cyc_q[0], 5);

      // Same stream with a throttled byte_valid
      run_load(2, 1'b1, -1, 8'h00, 1'b1);

      // Random contents and lengths
      for (int t = 0; t < 3; t++) begin
         fill_random(1 + t);
         run_load(1 + t, 1'b1, -1, 8'h00, 1'b1);
      end

      // Zero-length load completes with no writes
      stim_q.delete();
      run_load(0, 1'b0, -1, 8'h00, 1'b1);

      // Abort two bytes into word 3, byte offered in the abort cycle
      fill_random(5);
      run_load(5, 1'b1, 14, 8'h00, 1'b0);
      // Next start clears load_err (checked at start)
      fill_random(1);
      run_load(1, 1'b0, -1, 8'h00, 1'b1);

      // Count 0x4001: last word wraps to address 0
      fill_random(16'h4001);
      run_load(16'h4001, 1'b0, -1, 8'h00, 1'b1);
      check("wrap_last_addr", last_wr_addr, 0);

`ifdef IMEM_LOAD_CKSUM_EN
      // Bad checksum byte 0x0B, then the good one 0x0A
      stim_q = '{8'h01, 8'h02, 8'h03, 8'h04};
      run_load(1, 1'b0, -1, 8'h01, 1'b0);
      repeat (3) @(negedge clk);
      check("hold_sticks", cpu_hold, 1);
      run_load(1, 1'b0, -1, 8'h00, 1'b1);
`endif

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Boot-time controller that owns the instruction-ROM write port and shares the single ROM port between the fetch stage and a byte-stream loader. On `start` it holds the CPU, accepts a length-prefixed byte stream, packs bytes little-endian into 32-bit words, and writes them to consecutive ROM addresses. When the load completes it returns the port to the fetch stage. It sits between the UART byte receiver and the program ROM, beside the fetch stage.

## Interface
Parameters:
- `ADDR_W`, 14, ROM word-address width (16K words)
- `LEN_W`, 16, width of the word-count header

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse to begin a load; ignored unless IDLE
- `abort`  in  1  cancels an in-progress load
- `byte_valid`  in  1  stream byte present
- `byte_data`  in  8  stream byte
- `byte_ready`  out  1  controller accepts `byte_data` this cycle
- `fetch_addr`  in  ADDR_W  fetch-stage word address (PC[ADDR_W+1:2])
- `rom_addr`  out  ADDR_W  muxed ROM address
- `rom_wen`  out  1  ROM write enable
- `rom_din`  out  32  ROM write data
- `cpu_hold`  out  1  holds the PC/core while the loader owns the ROM
- `busy`  out  1  load in progress
- `done`  out  1  one-cycle pulse on successful completion
- `load_err`  out  1  sticky error flag; cleared by `start` or `rst`

## Operation
- States: IDLE, LEN0, LEN1, DATA, WRITE, CKSUM (macro only), DONE.
- IDLE: fetch owns the port (`rom_addr=fetch_addr`, `rom_wen=0`). `start` -> LEN0, clear `load_err`, word pointer=0, checksum=0.
- Byte transfer happens when `byte_valid & byte_ready` on a rising edge. `byte_ready=1` only in LEN0, LEN1, DATA, CKSUM.
- LEN0/LEN1 capture the word count: low byte, then high byte. If count=0 after LEN1, go to CKSUM (macro) or DONE. Otherwise go to DATA with byte index=0.
- DATA: byte k goes to bits [8k+7:8k]. The 4th byte goes to WRITE.
- WRITE: exactly one cycle with `rom_wen=1`, `rom_addr`=word pointer, `rom_din`=packed word. Then pointer+1 and remaining count-1. If remaining is now 0, go to CKSUM/DONE; otherwise go to DATA.
- Pointer wraps modulo 2^ADDR_W. A count above 2^ADDR_W overwrites from address 0 without error.
- DONE: `done=1` for one cycle, then IDLE.
- Outside IDLE: `cpu_hold=1`, `busy=1`, `rom_addr`=word pointer, and `rom_wen=0` except in WRITE.
- `abort` in any non-IDLE state: next state IDLE, `load_err=1`, no further writes. A word partly assembled at abort is dropped. `abort` in IDLE is ignored.
- `abort` and a byte handshake in the same cycle: `abort` wins and the byte is discarded.
- `start` while busy is ignored.

## Timing
- Reset values: state IDLE, `byte_ready=0`, `rom_wen=0`, `rom_din=0`, `cpu_hold=0`, `busy=0`, `done=0`, `load_err=0`. `rom_addr=fetch_addr` after reset.
- `rst` mid-load behaves the same as reset. The ROM keeps whatever words were already written.
- `start` at edge N gives `busy`, `cpu_hold` and `byte_ready` high from cycle N+1.
- With `byte_valid` held high, one word costs 5 cycles: 4 byte cycles plus 1 WRITE.
- `rom_wen` rises in the cycle after the 4th byte is accepted.
- `done` is asserted in the cycle after the final WRITE (or after the CKSUM byte). `cpu_hold` falls in the cycle after `done`.
- All outputs are registered except `rom_addr`, which is a combinational mux of state and `fetch_addr`. This mux is the fetch path's only added delay.

## Configuration
- `IMEM_LOAD_CKSUM_EN` defined:
  - An 8-bit running sum (mod 256) is kept over all DATA bytes.
  - After the last word, state CKSUM accepts one byte.
  - If the byte equals the sum: DONE.
  - If it mismatches: `load_err=1`, return to IDLE without a `done` pulse, and `cpu_hold` stays 1 until the next successful load.
- Not defined: the CKSUM state and the sum register are absent. The path after the last WRITE goes straight to DONE. `load_err` is set only by `abort`.

## Structure
- The shared package `imem_pkg` holds:
  - the state enum
  - `IMEM_ADDR_W=14`
  - `IMEM_LEN_W=16`
  - `WORD_BYTES=4`
- One sub-module, `byte_packer`, holds the 2-bit byte index and the 32-bit shift assembly, with clear, load and full outputs. The FSM, port mux and counters stay in the top level.

## Test plan
- Reset, then idle with `fetch_addr=0x0123` -> `rom_addr=0x0123`, `rom_wen=0`, `cpu_hold=0`, `done=0`.
- `start`, then bytes 02 00 | 78 56 34 12 | EF BE AD DE at full rate -> writes [0]=0x12345678 and [1]=0xDEADBEEF, each with a one-cycle `rom_wen` exactly 5 cycles apart. `done` pulses once and `cpu_hold` falls the next cycle.
- `byte_valid` toggled randomly during the same load -> identical writes, and no byte accepted during WRITE.
- Count=0x4001 -> the last word is written at address 0x0000 (wrap), then `done`.
- `abort` after 2 data bytes of word 3 -> no write at address 3, `load_err=1`, IDLE. A following `start` clears `load_err`.
- Checksum (macro): count=1, word bytes 01 02 03 04, CKSUM byte 0x0A -> `done`. CKSUM byte 0x0B -> `load_err=1`, no `done`, `cpu_hold` stays 1.
